// File: rtl/step_phase_decoder.sv
// Stepper coil phase decoder.
// Synchronizes the four coil drive lines, debounces the code and tracks the
// one-hot phase sequence to keep a signed net step count, flagging skipped
// steps and illegal coil patterns.
module step_phase_decoder #(
    parameter int unsigned POS_WIDTH     = 16,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  phase_in,
    input  logic                        clear,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        dir,
    output logic                        step_pulse,
    output logic                        err_pulse,
    output logic [7:0]                  err_count,
    output logic                        locked,
    output logic                        idle
);

    // Wide enough to hold STABLE_CYCLES itself.
    localparam int unsigned CntW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

    typedef enum logic [0:0] {
        StUnlocked,
        StLocked
    } state_e;

    // Synchronizer and filter state
    logic [3:0]          sync1_q;
    logic [3:0]          sync2_q;
    logic [3:0]          cand_q;
    logic [3:0]          accepted_q;
    logic [CntW-1:0]     stable_cnt_q;
    logic                accept_fire;

    // Tracker state and registered outputs
    state_e              state_q;
    logic [1:0]          ref_idx_q;
    logic [POS_WIDTH-1:0] pos_q;
    logic                dir_q;
    logic                step_q;
    logic                err_q;
    logic [7:0]          err_count_q;
    logic                idle_q;

    // Decode of the candidate being accepted
    logic                code_legal;
    logic [1:0]          code_idx;
    logic [1:0]          delta;
    logic                ev_lock;
    logic                ev_fwd;
    logic                ev_rev;
    logic                ev_skip;
    logic                ev_illegal;
    logic                ev_any_err;

    // The candidate is accepted once it has been stable long enough and is a new code.
    assign accept_fire = (stable_cnt_q == CntW'(STABLE_CYCLES)) && (cand_q != accepted_q);

    // Two-flop synchronizer followed by the stability filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 4'b0000;
            sync2_q      <= 4'b0000;
            cand_q       <= 4'b0000;
            accepted_q   <= 4'b0000;
            stable_cnt_q <= '0;
        end else begin
            sync1_q <= phase_in;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                // A fresh code counts as its first matching cycle.
                cand_q       <= sync2_q;
                stable_cnt_q <= CntW'(1);
            end else if (stable_cnt_q != CntW'(STABLE_CYCLES)) begin
                stable_cnt_q <= stable_cnt_q + CntW'(1);
            end
            if (accept_fire) begin
                accepted_q <= cand_q;
            end
        end
    end

    // Map the candidate code to its phase index.
    always_comb begin
        code_legal = 1'b1;
        code_idx   = 2'd0;
        case (cand_q)
            4'b1000: code_idx = 2'd0;
            4'b0100: code_idx = 2'd1;
            4'b0010: code_idx = 2'd2;
            4'b0001: code_idx = 2'd3;
            default: code_legal = 1'b0;
        endcase
    end

    // Distance from the reference phase, wrapping mod 4.
    assign delta = code_idx - ref_idx_q;

    // Classify the acceptance event against the current tracker state.
    always_comb begin
        ev_lock    = 1'b0;
        ev_fwd     = 1'b0;
        ev_rev     = 1'b0;
        ev_skip    = 1'b0;
        ev_illegal = 1'b0;
        if (accept_fire && (cand_q != 4'b0000)) begin
            if (!code_legal) begin
                // Illegal patterns only matter once a reference is held.
                ev_illegal = (state_q == StLocked);
            end else if (state_q == StUnlocked) begin
                ev_lock = 1'b1;
            end else begin
                // Delta 0 occurs only when returning from 0000 to the retained phase.
                case (delta)
                    2'd1:    ev_fwd  = 1'b1;
                    2'd3:    ev_rev  = 1'b1;
                    2'd2:    ev_skip = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign ev_any_err = ev_skip | ev_illegal;

    // Tracker FSM with registered step/error strobes, position and error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StUnlocked;
            ref_idx_q   <= 2'd0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
            idle_q      <= 1'b1;
        end else begin
            step_q <= ev_fwd | ev_rev;
            err_q  <= ev_any_err;

            if (accept_fire) begin
                idle_q <= (cand_q == 4'b0000);
            end

            case (state_q)
                StUnlocked: begin
                    if (ev_lock) begin
                        state_q <= StLocked;
                    end
                end
                StLocked: begin
                    if (ev_illegal) begin
                        state_q <= StUnlocked;
                    end
                end
                default: state_q <= StUnlocked;
            endcase

            if (ev_lock || ev_fwd || ev_rev || ev_skip) begin
                ref_idx_q <= code_idx;
            end

            if (ev_fwd) begin
                dir_q <= 1'b1;
            end else if (ev_rev) begin
                dir_q <= 1'b0;
            end

            // Clear wins over a coincident step; the strobe and dir still update.
            if (clear) begin
                pos_q <= '0;
            end else if (ev_fwd) begin
                pos_q <= pos_q + POS_WIDTH'(1);
            end else if (ev_rev) begin
                pos_q <= pos_q - POS_WIDTH'(1);
            end

            if (ev_any_err && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign position   = pos_q;
    assign dir        = dir_q;
    assign step_pulse = step_q;
    assign err_pulse  = err_q;
    assign err_count  = err_count_q;
    assign locked     = (state_q == StLocked);
    assign idle       = idle_q;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Bench for step_phase_decoder: vector table, hand-written corner sequences
// and randomized codes checked against a code-level behavioural model.
module tb_step_phase_decoder;

    localparam int PW = 16;
    localparam int SC = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clear;
    logic [3:0]           phase_in;
    logic signed [PW-1:0] position;
    logic                 dir;
    logic                 step_pulse;
    logic                 err_pulse;
    logic [7:0]           err_count;
    logic                 locked;
    logic                 idle;
    logic [PW-1:0]        pos_u;

    assign pos_u = position;

    step_phase_decoder #(
        .POS_WIDTH    (PW),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .phase_in  (phase_in),
        .clear     (clear),
        .position  (position),
        .dir       (dir),
        .step_pulse(step_pulse),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .locked    (locked),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int steps_seen = 0;
    int errs_seen = 0;
    int overlap_seen = 0;
    int s0 = 0;
    int e0 = 0;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (step_pulse) steps_seen <= steps_seen + 1;
        if (err_pulse) errs_seen <= errs_seen + 1;
        if (step_pulse && err_pulse) overlap_seen <= overlap_seen + 1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: works on whole accepted codes and phase indices.
    int         m_pos;
    int         m_dir;
    int         m_locked;
    int         m_ref;
    int         m_idle;
    int         m_errcnt;
    logic [3:0] m_acc;

    function automatic int onehot_index(input logic [3:0] c);
        if ($countones(c) != 1) return -1;
        for (int i = 0; i < 4; i++) begin
            if (c == (4'b1000 >> i)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_dir = 0; m_locked = 0; m_ref = 0; m_idle = 1; m_errcnt = 0;
        m_acc = 4'b0000;
    endtask

    task automatic model_err();
        if (m_errcnt < 255) m_errcnt++;
    endtask

    task automatic model_accept(input logic [3:0] code, output int st, output int er);
        int idx;
        int d;
        st = 0;
        er = 0;
        if (code == m_acc) return;
        m_acc  = code;
        m_idle = (code == 4'b0000) ? 1 : 0;
        if (code == 4'b0000) return;
        idx = onehot_index(code);
        if (m_locked == 0) begin
            if (idx >= 0) begin
                m_locked = 1;
                m_ref    = idx;
            end
            return;
        end
        if (idx < 0) begin
            er = 1; m_locked = 0; model_err();
            return;
        end
        d = (idx - m_ref + 4) % 4;
        if (d == 1) begin
            st = 1; m_dir = 1; m_pos = (m_pos + 1) % 65536;
        end else if (d == 3) begin
            st = 1; m_dir = 0; m_pos = (m_pos + 65535) % 65536;
        end else if (d == 2) begin
            er = 1; model_err();
        end
        m_ref = idx;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clear = 1'b0; phase_in = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drive an optional glitch then a code, hold it, and stop just after a negedge.
    task automatic drive(input logic [3:0] code, input int hold,
                         input logic [3:0] gl_code, input int gl_len);
        @(negedge clk);
        #1;
        s0 = steps_seen;
        e0 = errs_seen;
        if (gl_len > 0) begin
            phase_in = gl_code;
            repeat (gl_len) @(negedge clk);
        end
        phase_in = code;
        repeat (hold) @(negedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] code, input int hold);
        drive(code, hold, 4'b0000, 0);
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [15:0] pos;
        logic        dir;
        logic        lk;
        logic        idl;
        int          st;
        int          er;
        logic [7:0]  ec;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int lat;
        int st;
        int er;
        logic [3:0] code;
        logic [3:0] gcode;
        int glen;
        int hold;

        tbl[0]  = '{4'b1000, 16'd0, 1'b0, 1'b1, 1'b0, 0, 0, 8'd0};
        tbl[1]  = '{4'b0100, 16'd1, 1'b1, 1'b1, 1'b0, 1, 0, 8'd0};
        tbl[2]  = '{4'b0010, 16'd2, 1'b1, 1'b1, 1'b0, 1, 0, 8'd0};
        tbl[3]  = '{4'b0001, 16'd3, 1'b1, 1'b1, 1'b0, 1, 0, 8'd0};
        tbl[4]  = '{4'b1000, 16'd4, 1'b1, 1'b1, 1'b0, 1, 0, 8'd0};
        tbl[5]  = '{4'b0010, 16'd4, 1'b1, 1'b1, 1'b0, 0, 1, 8'd1};
        tbl[6]  = '{4'b0000, 16'd4, 1'b1, 1'b1, 1'b1, 0, 0, 8'd1};
        tbl[7]  = '{4'b0001, 16'd5, 1'b1, 1'b1, 1'b0, 1, 0, 8'd1};
        tbl[8]  = '{4'b1100, 16'd5, 1'b1, 1'b0, 1'b0, 0, 1, 8'd2};
        tbl[9]  = '{4'b0100, 16'd5, 1'b1, 1'b1, 1'b0, 0, 0, 8'd2};
        tbl[10] = '{4'b0010, 16'd6, 1'b1, 1'b1, 1'b0, 1, 0, 8'd2};
        tbl[11] = '{4'b0100, 16'd5, 1'b0, 1'b1, 1'b0, 1, 0, 8'd2};
        tbl[12] = '{4'b0000, 16'd5, 1'b0, 1'b1, 1'b1, 0, 0, 8'd2};
        tbl[13] = '{4'b1000, 16'd4, 1'b0, 1'b1, 1'b0, 1, 0, 8'd2};

        rst = 1'b1; clear = 1'b0; phase_in = 4'b0000;

        // Reset state
        do_reset();
        @(negedge clk);
        #1;
        check("rst_pos", pos_u, 0);
        check("rst_dir", dir, 0);
        check("rst_step", step_pulse, 0);
        check("rst_err", err_pulse, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_locked", locked, 0);
        check("rst_idle", idle, 1);

        // Vector table: forward run, skip, idle, illegal, relock, reverse
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].code, 10);
            check($sformatf("tbl%0d_pos", i), pos_u, tbl[i].pos);
            check($sformatf("tbl%0d_dir", i), dir, tbl[i].dir);
            check($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
            check($sformatf("tbl%0d_idle", i), idle, tbl[i].idl);
            check($sformatf("tbl%0d_steps", i), steps_seen - s0, tbl[i].st);
            check($sformatf("tbl%0d_errs", i), errs_seen - e0, tbl[i].er);
            check($sformatf("tbl%0d_errcnt", i), err_count, tbl[i].ec);
        end

        // Latency from first sampling edge to step and error strobes
        do_reset();
        apply(4'b1000, 10);
        @(negedge clk);
        phase_in = 4'b0100;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (step_pulse && lat == 0) lat = k;
        end
        check("step_latency", lat, SC + 3);
        @(negedge clk);
        phase_in = 4'b0001;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (err_pulse && lat == 0) lat = k;
        end
        check("err_latency", lat, SC + 3);

        // Reset mid-filter aborts the pending step; the code then only locks
        do_reset();
        apply(4'b1000, 10);
        @(negedge clk);
        #1;
        s0 = steps_seen;
        phase_in = 4'b0100;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("midrst_steps", steps_seen - s0, 0);
        check("midrst_locked", locked, 1);
        check("midrst_pos", pos_u, 0);
        check("midrst_idle", idle, 0);

        // Reverse through zero after a clear
        do_reset();
        apply(4'b1000, 10);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        apply(4'b0001, 10);
        apply(4'b0010, 10);
        check("wrap_pos", pos_u, 16'hFFFE);
        check("wrap_dir", dir, 0);

        // Clear coincident with a forward step
        @(negedge clk);
        #1;
        s0 = steps_seen;
        phase_in = 4'b0001;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clrcol_step", step_pulse, 1);
        check("clrcol_pos", pos_u, 0);
        repeat (4) @(negedge clk);
        #1;
        check("clrcol_pos_hold", pos_u, 0);
        check("clrcol_dir", dir, 1);
        check("clrcol_steps", steps_seen - s0, 1);

        // Skip: 0001 -> 0100
        apply(4'b0100, 10);
        check("skip_errs", errs_seen - e0, 1);
        check("skip_errcnt", err_count, 1);
        check("skip_pos", pos_u, 0);
        check("skip_steps", steps_seen - s0, 0);

        // Two-cycle glitch must produce nothing
        drive(4'b0100, 15, 4'b0001, 2);
        check("glitch_steps", steps_seen - s0, 0);
        check("glitch_errs", errs_seen - e0, 0);
        check("glitch_pos", pos_u, 0);

        // Illegal code unlocks
        apply(4'b1100, 10);
        check("illegal_errs", errs_seen - e0, 1);
        check("illegal_locked", locked, 0);
        check("illegal_errcnt", err_count, 2);

        // Error counter saturation
        do_reset();
        apply(4'b1000, 10);
        s0 = steps_seen;
        e0 = errs_seen;
        for (int i = 0; i < 300; i++) begin
            phase_in = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            repeat (8) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        #1;
        check("sat_errcnt", err_count, 255);
        check("sat_errs", errs_seen - e0, 300);
        check("sat_steps", steps_seen - s0, 0);
        check("sat_pos", pos_u, 0);

        // Randomized codes against the model
        do_reset();
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: code = 4'b1000 >> $urandom_range(0, 3);
                6, 7:             code = 4'b0000;
                default: begin
                    code = 4'($urandom_range(1, 15));
                    while ($countones(code) < 2) code = 4'($urandom_range(1, 15));
                end
            endcase
            gcode = 4'($urandom_range(0, 15));
            glen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            hold = int'($urandom_range(8, 14));
            drive(code, hold, gcode, glen);
            model_accept(code, st, er);
            check($sformatf("rnd%0d_pos", it), pos_u, m_pos[15:0]);
            check($sformatf("rnd%0d_dir", it), dir, m_dir[0]);
            check($sformatf("rnd%0d_locked", it), locked, m_locked[0]);
            check($sformatf("rnd%0d_idle", it), idle, m_idle[0]);
            check($sformatf("rnd%0d_errcnt", it), err_count, m_errcnt[7:0]);
            check($sformatf("rnd%0d_steps", it), steps_seen - s0, st);
            check($sformatf("rnd%0d_errs", it), errs_seen - e0, er);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                m_pos = 0;
            end
        end

        check("no_overlap", overlap_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_phase_decoder.md
STEP_PHASE_DECODER -- requirements
Module: step_phase_decoder

Interface
REQ-001 Parameter POS_WIDTH, default 16: width of the signed position counter.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive cycles a synchronized code must hold before it is accepted.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 phase_in  in  4  stepper coil drive lines, asynchronous to clk.
REQ-006 clear  in  1  synchronous request to zero position.
REQ-007 position  out  POS_WIDTH  signed two's-complement net step count.
REQ-008 dir  out  1  direction of last counted step: 1 = forward, 0 = reverse.
REQ-009 step_pulse  out  1  one-cycle strobe per counted step.
REQ-010 err_pulse  out  1  one-cycle strobe per detected sequence error.
REQ-011 err_count  out  8  saturating count of errors.
REQ-012 locked  out  1  high when a valid phase reference is held.
REQ-013 idle  out  1  high while the accepted code is 4'b0000 (coils de-energized).

Function
REQ-014 phase_in shall pass through a 2-flop synchronizer before any other use.
REQ-015 Filter: a candidate register tracks the synchronized code; the stable counter resets on any mismatch.
REQ-016 Filter: the code is accepted when it has matched the candidate for STABLE_CYCLES consecutive cycles and differs from the currently accepted code.
REQ-017 Acceptance-to-output latency: step_pulse/err_pulse assert exactly STABLE_CYCLES+3 rising edges after the first edge that samples the new phase_in (7 at default).
REQ-018 Legal codes and indices: 4'b1000 = 0, 4'b0100 = 1, 4'b0010 = 2, 4'b0001 = 3.
REQ-019 Forward direction is increasing index mod 4.
REQ-020 FSM state UNLOCKED (reset state):
 - accepted legal code: load reference index, go LOCKED, no step, no error.
 - accepted 4'b0000: set idle, stay UNLOCKED.
 - accepted other code: ignored.
REQ-021 FSM state LOCKED, on accepted code with delta = (new - ref) mod 4:
 - delta 1: position +1, dir=1, step_pulse, ref=new.
 - delta 3: position -1, dir=0, step_pulse, ref=new.
 - delta 2 (skipped step): err_pulse, ref=new, position unchanged, stay LOCKED.
REQ-022 LOCKED, accepted 4'b0000: idle=1, no error, ref retained, stay LOCKED; a following legal code is evaluated against the retained ref.
REQ-023 LOCKED, accepted non-one-hot nonzero code: err_pulse, go UNLOCKED, position retained.
REQ-024 idle shall deassert on acceptance of any nonzero code.
REQ-025 position shall wrap modulo 2^POS_WIDTH (0x7FFF + 1 = 0x8000).
REQ-026 clear shall set position to 0 on the next edge and take priority over a simultaneous step; step_pulse and dir still update.
REQ-027 err_count shall increment once per err_pulse and saturate at 255; only rst clears it.
REQ-028 step_pulse and err_pulse shall never assert in the same cycle.
REQ-029 locked shall equal (state == LOCKED).

Reset
REQ-030 rst shall return the following to the reset state below:
 - synchronizer, candidate, stable counter and accepted code: 4'b0000.
 - state: UNLOCKED.
 - position: 0; dir: 0; step_pulse: 0; err_pulse: 0; err_count: 0; locked: 0; idle: 1.
REQ-031 rst asserted mid-filter or mid-step shall abort it; the next code is evaluated as from UNLOCKED.

Verification
REQ-032 Forward sequence:
 - stimulus: after reset, 1000,0100,0010,0001,1000, each held 10 cycles.
 - response: locked=1 after the first code; four step_pulses, each 7 cycles after its edge; position=4; dir=1.
REQ-033 Reverse and wrap:
 - stimulus: POS_WIDTH=16, position preloaded to 0 via clear, then steps 1000→0001→0010.
 - response: position=0xFFFE; dir=0.
REQ-034 Skip and glitch:
 - stimulus: 1000→0010.
 - response: err_pulse, err_count=1, position unchanged.
 - stimulus: a 2-cycle glitch to 0100.
 - response: no pulse of any kind.
REQ-035 Illegal and idle:
 - stimulus: LOCKED then 1100.
 - response: err_pulse, locked=0.
 - stimulus: LOCKED then 0000 then the next forward code.
 - response: idle=1 during 0000, then one step_pulse, no error.
REQ-036 Clear collision and saturation:
 - stimulus: clear coincident with a forward step.
 - response: position=0, step_pulse=1.
 - stimulus: 300 skip errors.
 - response: err_count=255.
